// File: rtl/math_engine_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : math_engine_pkg
//  Description : Shared constants, CTRL layout, opcodes and FSM state type
//                for the iterative math engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package math_engine_pkg;

    localparam int HBIT_DATA    = 23;
    localparam int HBIT_TGT_CSR = 4;

    // CSR indices reachable through the auxiliary write port
    localparam logic [HBIT_TGT_CSR:0] CSR_IDX_MATH_CTRL   = 5'd8;
    localparam logic [HBIT_TGT_CSR:0] CSR_IDX_MATH_OPA    = 5'd9;
    localparam logic [HBIT_TGT_CSR:0] CSR_IDX_MATH_OPB    = 5'd10;
    localparam logic [HBIT_TGT_CSR:0] CSR_IDX_MATH_OPC    = 5'd11;
    localparam logic [HBIT_TGT_CSR:0] CSR_IDX_MATH_RES_LO = 5'd12;
    localparam logic [HBIT_TGT_CSR:0] CSR_IDX_MATH_RES_HI = 5'd13;

    // CTRL register bit positions
    localparam int MATH_CTRL_START  = 0;
    localparam int MATH_CTRL_BUSY   = 1;
    localparam int MATH_CTRL_DONE   = 2;
    localparam int MATH_CTRL_ERR    = 3;
    localparam int MATH_CTRL_OP_LSB = 4;
    localparam int MATH_CTRL_OP_MSB = 7;

    // Opcodes
    localparam logic [3:0] MATH_OP_MULU  = 4'd0;
    localparam logic [3:0] MATH_OP_DIVU  = 4'd1;
    localparam logic [3:0] MATH_OP_MACU  = 4'd2;
    localparam logic [3:0] MATH_OP_SQRTU = 4'd3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACK     = 3'd1,
        ST_RUN     = 3'd2,
        ST_WR_LO   = 3'd3,
        ST_WR_HI   = 3'd4,
        ST_WR_CTRL = 3'd5
    } math_state_t;

    // Builds a CTRL word; START and the reserved bits are always written as 0
    function automatic logic [HBIT_DATA:0] math_ctrl_word(
        input logic [3:0] op,
        input logic       err,
        input logic       done,
        input logic       busy
    );
        logic [HBIT_DATA:0] w_word;
        w_word = '0;
        w_word[MATH_CTRL_OP_MSB:MATH_CTRL_OP_LSB] = op;
        w_word[MATH_CTRL_ERR]  = err;
        w_word[MATH_CTRL_DONE] = done;
        w_word[MATH_CTRL_BUSY] = busy;
        return w_word;
    endfunction

endpackage
`default_nettype wire

// File: rtl/math_engine_if.sv
`default_nettype none
// ============================================================================
//  Module      : math_engine_if
//  Description : CSR taps into the math engine and its auxiliary CSR write
//                port / status outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
interface math_engine_if;
    import math_engine_pkg::*;

    logic [HBIT_DATA:0]    iw_math_ctrl;
    logic [HBIT_DATA:0]    iw_math_opa;
    logic [HBIT_DATA:0]    iw_math_opb;
    logic [HBIT_DATA:0]    iw_math_opc;
    logic                  ow_w2_enable;
    logic [HBIT_TGT_CSR:0] ow_w2_addr;
    logic [HBIT_DATA:0]    ow_w2_data;
    logic                  ow_busy;
    logic                  ow_done;

    // Engine side
    modport master (
        input  iw_math_ctrl, iw_math_opa, iw_math_opb, iw_math_opc,
        output ow_w2_enable, ow_w2_addr, ow_w2_data, ow_busy, ow_done
    );

    // CSR file side
    modport slave (
        output iw_math_ctrl, iw_math_opa, iw_math_opb, iw_math_opc,
        input  ow_w2_enable, ow_w2_addr, ow_w2_data, ow_busy, ow_done
    );

endinterface
`default_nettype wire

// File: rtl/math_iter_core.sv
`default_nettype none
// ============================================================================
//  Module      : math_iter_core
//  Description : Shared 48-bit shift datapath: shift-add multiply (with
//                optional addend), restoring divide and digit-by-digit
//                integer square root. One iteration per i_step.
//  Revision    : 1.0 - initial release
// ============================================================================
module math_iter_core
    import math_engine_pkg::*;
(
    input  wire                 clk,
    input  wire                 rst_n,
    input  wire                 i_load,
    input  wire                 i_step,
    input  wire [3:0]           i_op,
    input  wire [HBIT_DATA:0]   i_a,
    input  wire [HBIT_DATA:0]   i_b,
    input  wire [HBIT_DATA:0]   i_c,
    output logic                o_last,
    output logic [HBIT_DATA:0]  o_lo,
    output logic [HBIT_DATA:0]  o_hi
);

    // r_x: mul multiplicand / sqrt root; r_y: mul multiplier / divisor /
    // sqrt radicand; r_acc: mul sum / {remainder,quotient} / sqrt remainder
    logic [3:0]         r_op;
    logic [4:0]         r_cnt;
    logic [47:0]        r_x;
    logic [HBIT_DATA:0] r_y;
    logic [47:0]        r_acc;

    logic [24:0] w_div_rem;
    logic [24:0] w_div_diff;
    logic [47:0] w_sq_rem;
    logic [47:0] w_sq_trial;

    // Trial subtractions for the divide and square-root iterations
    always_comb begin
        w_div_rem  = r_acc[47:23];
        w_div_diff = w_div_rem - {1'b0, r_y};
        w_sq_rem   = {r_acc[45:0], r_y[23:22]};
        w_sq_trial = {r_x[45:0], 2'b01};
    end

    // Iteration state: load on start, advance one step per i_step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op  <= '0;
            r_cnt <= '0;
            r_x   <= '0;
            r_y   <= '0;
            r_acc <= '0;
        end else if (i_load) begin
            r_op  <= i_op;
            r_cnt <= '0;
            r_x   <= '0;
            r_y   <= '0;
            r_acc <= '0;
            case (i_op)
                MATH_OP_MULU: begin
                    r_x <= {24'd0, i_a};
                    r_y <= i_b;
                end
                MATH_OP_MACU: begin
                    r_x   <= {24'd0, i_a};
                    r_y   <= i_b;
                    r_acc <= {24'd0, i_c};
                end
                MATH_OP_DIVU: begin
                    r_y   <= i_b;
                    r_acc <= {24'd0, i_a};
                end
                MATH_OP_SQRTU: begin
                    r_y <= i_a;
                end
                default: ;
            endcase
        end else if (i_step) begin
            r_cnt <= r_cnt + 5'd1;
            case (r_op)
                MATH_OP_MULU, MATH_OP_MACU: begin
                    if (r_y[0]) begin
                        r_acc <= r_acc + r_x;
                    end
                    r_x <= {r_x[46:0], 1'b0};
                    r_y <= {1'b0, r_y[HBIT_DATA:1]};
                end
                MATH_OP_DIVU: begin
                    if (!w_div_diff[24]) begin
                        r_acc <= {w_div_diff[23:0], r_acc[22:0], 1'b1};
                    end else begin
                        r_acc <= {w_div_rem[23:0], r_acc[22:0], 1'b0};
                    end
                end
                MATH_OP_SQRTU: begin
                    if (w_sq_rem >= w_sq_trial) begin
                        r_acc <= w_sq_rem - w_sq_trial;
                        r_x   <= {r_x[46:0], 1'b1};
                    end else begin
                        r_acc <= w_sq_rem;
                        r_x   <= {r_x[46:0], 1'b0};
                    end
                    r_y <= {r_y[21:0], 2'b00};
                end
                default: ;
            endcase
        end
    end

    // Terminal count and result selection
    always_comb begin
        o_last = (r_op == MATH_OP_SQRTU) ? (r_cnt == 5'd11) : (r_cnt == 5'd23);
        o_lo   = r_acc[23:0];
        o_hi   = r_acc[47:24];
        if (r_op == MATH_OP_SQRTU) begin
            o_lo = r_x[23:0];
            o_hi = r_acc[23:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/math_engine.sv
`default_nettype none
// ============================================================================
//  Module      : math_engine
//  Description : Iterative unsigned arithmetic unit fed by the math CSR taps;
//                sequences results and status back through the CSR file's
//                auxiliary write port.
//  Revision    : 1.0 - initial release
// ============================================================================
module math_engine
    import math_engine_pkg::*;
#(
    parameter bit P_SQRT_EN = 1'b1
)(
    input  wire          iw_clk,
    input  wire          iw_rst_n,
    math_engine_if.master bus
);

    math_state_t        r_state;
    math_state_t        w_next;
    logic [3:0]         r_op;
    logic [HBIT_DATA:0] r_opa;
    logic               r_err;
    logic               r_div0;

    logic                  w_load;
    logic                  w_step;
    logic                  w_w2_en;
    logic [HBIT_TGT_CSR:0] w_w2_addr;
    logic [HBIT_DATA:0]    w_w2_data;
    logic [3:0]            w_tap_op;
    logic                  w_invalid;
    logic                  w_div0;
    logic                  w_core_last;
    logic [HBIT_DATA:0]    w_core_lo;
    logic [HBIT_DATA:0]    w_core_hi;

    // Decode the opcode currently sitting in the CTRL tap
    always_comb begin
        w_tap_op  = bus.iw_math_ctrl[MATH_CTRL_OP_MSB:MATH_CTRL_OP_LSB];
        w_invalid = (w_tap_op > MATH_OP_SQRTU) ||
                    ((w_tap_op == MATH_OP_SQRTU) && !P_SQRT_EN);
        w_div0    = (w_tap_op == MATH_OP_DIVU) && (bus.iw_math_opb == '0);
    end

    // State register
    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Latch the command at START so later CPU writes cannot disturb it
    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            r_op   <= '0;
            r_opa  <= '0;
            r_err  <= 1'b0;
            r_div0 <= 1'b0;
        end else if (w_load) begin
            r_op   <= w_tap_op;
            r_opa  <= bus.iw_math_opa;
            r_err  <= w_invalid || w_div0;
            r_div0 <= w_div0;
        end
    end

    // Next state and w2 write sequencing; at most one write per state
    always_comb begin
        w_next    = r_state;
        w_load    = 1'b0;
        w_step    = 1'b0;
        w_w2_en   = 1'b0;
        w_w2_addr = '0;
        w_w2_data = '0;
        case (r_state)
            ST_IDLE: begin
                if (bus.iw_math_ctrl[MATH_CTRL_START]) begin
                    w_load = 1'b1;
                    w_next = ST_ACK;
                end
            end
            ST_ACK: begin
                w_w2_en   = 1'b1;
                w_w2_addr = CSR_IDX_MATH_CTRL;
                w_w2_data = math_ctrl_word(r_op, 1'b0, 1'b0, 1'b1);
                // Divide-by-zero still reports its fixed result words
                if (r_div0) begin
                    w_next = ST_WR_LO;
                end else if (r_err) begin
                    w_next = ST_WR_CTRL;
                end else begin
                    w_next = ST_RUN;
                end
            end
            ST_RUN: begin
                w_step = 1'b1;
                if (w_core_last) begin
                    w_next = ST_WR_LO;
                end
            end
            ST_WR_LO: begin
                w_w2_en   = 1'b1;
                w_w2_addr = CSR_IDX_MATH_RES_LO;
                w_w2_data = r_div0 ? '1 : w_core_lo;
                w_next    = ST_WR_HI;
            end
            ST_WR_HI: begin
                w_w2_en   = 1'b1;
                w_w2_addr = CSR_IDX_MATH_RES_HI;
                w_w2_data = r_div0 ? r_opa : w_core_hi;
                w_next    = ST_WR_CTRL;
            end
            ST_WR_CTRL: begin
                // Writing START=0 here is what prevents an immediate retrigger
                w_w2_en   = 1'b1;
                w_w2_addr = CSR_IDX_MATH_CTRL;
                w_w2_data = math_ctrl_word(r_op, r_err, 1'b1, 1'b0);
                w_next    = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    assign bus.ow_w2_enable = w_w2_en;
    assign bus.ow_w2_addr   = w_w2_addr;
    assign bus.ow_w2_data   = w_w2_data;
    assign bus.ow_busy      = (r_state != ST_IDLE);
    assign bus.ow_done      = (r_state == ST_WR_CTRL);

    math_iter_core u_core (
        .clk    (iw_clk),
        .rst_n  (iw_rst_n),
        .i_load (w_load),
        .i_step (w_step),
        .i_op   (w_tap_op),
        .i_a    (bus.iw_math_opa),
        .i_b    (bus.iw_math_opb),
        .i_c    (bus.iw_math_opc),
        .o_last (w_core_last),
        .o_lo   (w_core_lo),
        .o_hi   (w_core_hi)
    );

endmodule
`default_nettype wire

// File: tb/tb_math_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_math_engine
//  Description : Directed self-checking bench for math_engine with a small
//                CSR-file model (w2 wins on collisions, reset by ~iw_rst_n).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_math_engine;
    import math_engine_pkg::*;

    logic iw_clk   = 1'b0;
    logic iw_rst_n = 1'b0;
    always #5 iw_clk = ~iw_clk;

    math_engine_if u_if ();

    math_engine #(.P_SQRT_EN(1'b1)) dut (
        .iw_clk   (iw_clk),
        .iw_rst_n (iw_rst_n),
        .bus      (u_if.master)
    );

    logic [23:0] csr [0:31];
    logic        cpu_we   = 1'b0;
    logic [4:0]  cpu_addr = '0;
    logic [23:0] cpu_data = '0;
    int          res_writes = 0;
    int          checks = 0;
    int          errors = 0;

    assign u_if.iw_math_ctrl = csr[CSR_IDX_MATH_CTRL];
    assign u_if.iw_math_opa  = csr[CSR_IDX_MATH_OPA];
    assign u_if.iw_math_opb  = csr[CSR_IDX_MATH_OPB];
    assign u_if.iw_math_opc  = csr[CSR_IDX_MATH_OPC];

    // CSR file model: engine write is applied last so it wins a collision
    always @(posedge iw_clk) begin
        if (!iw_rst_n) begin
            for (int i = 0; i < 32; i++) csr[i] <= '0;
        end else begin
            if (cpu_we) csr[cpu_addr] <= cpu_data;
            if (u_if.ow_w2_enable) csr[u_if.ow_w2_addr] <= u_if.ow_w2_data;
        end
    end

    // Count result-register writes
    always @(posedge iw_clk) begin
        if (iw_rst_n && u_if.ow_w2_enable &&
            (u_if.ow_w2_addr == CSR_IDX_MATH_RES_LO || u_if.ow_w2_addr == CSR_IDX_MATH_RES_HI))
            res_writes <= res_writes + 1;
    end

    task automatic cpu_write(input logic [4:0] a, input logic [23:0] d);
        cpu_we = 1'b1; cpu_addr = a; cpu_data = d;
        @(posedge iw_clk); #1;
        cpu_we = 1'b0;
    endtask

    // Returns in cycle 0 (START visible to the engine)
    task automatic kick(input logic [3:0] op, input logic [23:0] a, input logic [23:0] b,
                        input logic [23:0] c);
        cpu_write(CSR_IDX_MATH_OPA, a);
        cpu_write(CSR_IDX_MATH_OPB, b);
        cpu_write(CSR_IDX_MATH_OPC, c);
        cpu_write(CSR_IDX_MATH_CTRL, {16'h0, op, 4'h1});
    endtask

    // Waits until CTRL.DONE reads 1; optionally rewrites OPA then CTRL.START mid-run
    task automatic wait_done(input int disturb_at, output int done_cyc, output int ctrl_cyc,
                             output int pulses);
        done_cyc = -1; ctrl_cyc = -1; pulses = 0;
        for (int cyc = 1; cyc <= 60 && ctrl_cyc < 0; cyc++) begin
            @(posedge iw_clk); #1;
            if (u_if.ow_done) begin
                pulses++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (csr[CSR_IDX_MATH_CTRL][MATH_CTRL_DONE]) ctrl_cyc = cyc;
            if (disturb_at > 0 && cyc == disturb_at) begin
                cpu_we = 1'b1; cpu_addr = CSR_IDX_MATH_OPA; cpu_data = 24'h000999;
            end else if (disturb_at > 0 && cyc == disturb_at + 1) begin
                cpu_addr = CSR_IDX_MATH_CTRL; cpu_data = 24'h000001;
            end else if (disturb_at > 0 && cyc == disturb_at + 2) begin
                cpu_we = 1'b0;
            end
        end
        checks++;
        if (ctrl_cyc < 0) begin
            errors++;
            $display("FAIL done_timeout: CTRL.DONE not seen within 60 cycles");
        end
    endtask

    task automatic test_reset();
        #1;
        checks++; if (u_if.ow_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", u_if.ow_busy); end
        checks++; if (u_if.ow_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", u_if.ow_done); end
        checks++; if (u_if.ow_w2_enable !== 1'b0) begin errors++; $display("FAIL rst_w2_en: got %b expected 0", u_if.ow_w2_enable); end
        checks++; if (u_if.ow_w2_addr !== 5'd0) begin errors++; $display("FAIL rst_w2_addr: got %h expected 0", u_if.ow_w2_addr); end
        checks++; if (u_if.ow_w2_data !== 24'd0) begin errors++; $display("FAIL rst_w2_data: got %h expected 0", u_if.ow_w2_data); end
        repeat (3) @(posedge iw_clk);
        #1 iw_rst_n = 1'b1;
        @(posedge iw_clk); #1;
    endtask

    task automatic test_mulu();
        int dc, cc, p;
        kick(MATH_OP_MULU, 24'h000123, 24'h000456, 24'h0);
        wait_done(0, dc, cc, p);
        checks++; if (dc !== 28) begin errors++; $display("FAIL mulu_done_cycle: got %0d expected 28", dc); end
        checks++; if (cc !== 29) begin errors++; $display("FAIL mulu_ctrl_cycle: got %0d expected 29", cc); end
        checks++; if (p !== 1) begin errors++; $display("FAIL mulu_pulses: got %0d expected 1", p); end
        checks++; if (csr[CSR_IDX_MATH_RES_LO] !== 24'h04EDC2) begin errors++; $display("FAIL mulu_lo: got %h expected 04edc2", csr[CSR_IDX_MATH_RES_LO]); end
        checks++; if (csr[CSR_IDX_MATH_RES_HI] !== 24'h000000) begin errors++; $display("FAIL mulu_hi: got %h expected 000000", csr[CSR_IDX_MATH_RES_HI]); end
        checks++; if (csr[CSR_IDX_MATH_CTRL] !== 24'h000004) begin errors++; $display("FAIL mulu_ctrl: got %h expected 000004", csr[CSR_IDX_MATH_CTRL]); end
    endtask

    task automatic test_mul_max();
        int dc, cc, p;
        kick(MATH_OP_MULU, 24'hFFFFFF, 24'hFFFFFF, 24'h0);
        wait_done(0, dc, cc, p);
        checks++; if (csr[CSR_IDX_MATH_RES_HI] !== 24'hFFFFFE) begin errors++; $display("FAIL mulmax_hi: got %h expected fffffe", csr[CSR_IDX_MATH_RES_HI]); end
        checks++; if (csr[CSR_IDX_MATH_RES_LO] !== 24'h000001) begin errors++; $display("FAIL mulmax_lo: got %h expected 000001", csr[CSR_IDX_MATH_RES_LO]); end
        kick(MATH_OP_MACU, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF);
        wait_done(0, dc, cc, p);
        checks++; if (csr[CSR_IDX_MATH_RES_HI] !== 24'hFFFFFF) begin errors++; $display("FAIL macmax_hi: got %h expected ffffff", csr[CSR_IDX_MATH_RES_HI]); end
        checks++; if (csr[CSR_IDX_MATH_RES_LO] !== 24'h000000) begin errors++; $display("FAIL macmax_lo: got %h expected 000000", csr[CSR_IDX_MATH_RES_LO]); end
        checks++; if (csr[CSR_IDX_MATH_CTRL] !== 24'h000024) begin errors++; $display("FAIL macmax_ctrl: got %h expected 000024", csr[CSR_IDX_MATH_CTRL]); end
        checks++; if (cc !== 29) begin errors++; $display("FAIL macmax_cycle: got %0d expected 29", cc); end
    endtask

    task automatic test_divu();
        int dc, cc, p;
        kick(MATH_OP_DIVU, 24'd1000, 24'd7, 24'h0);
        wait_done(0, dc, cc, p);
        checks++; if (csr[CSR_IDX_MATH_RES_LO] !== 24'h00008E) begin errors++; $display("FAIL div_lo: got %h expected 00008e", csr[CSR_IDX_MATH_RES_LO]); end
        checks++; if (csr[CSR_IDX_MATH_RES_HI] !== 24'h000006) begin errors++; $display("FAIL div_hi: got %h expected 000006", csr[CSR_IDX_MATH_RES_HI]); end
        checks++; if (csr[CSR_IDX_MATH_CTRL] !== 24'h000014) begin errors++; $display("FAIL div_ctrl: got %h expected 000014", csr[CSR_IDX_MATH_CTRL]); end
        checks++; if (cc !== 29) begin errors++; $display("FAIL div_cycle: got %0d expected 29", cc); end
        kick(MATH_OP_DIVU, 24'h000ABC, 24'h0, 24'h0);
        wait_done(0, dc, cc, p);
        checks++; if (csr[CSR_IDX_MATH_RES_LO] !== 24'hFFFFFF) begin errors++; $display("FAIL div0_lo: got %h expected ffffff", csr[CSR_IDX_MATH_RES_LO]); end
        checks++; if (csr[CSR_IDX_MATH_RES_HI] !== 24'h000ABC) begin errors++; $display("FAIL div0_hi: got %h expected 000abc", csr[CSR_IDX_MATH_RES_HI]); end
        checks++; if (csr[CSR_IDX_MATH_CTRL] !== 24'h00001C) begin errors++; $display("FAIL div0_ctrl: got %h expected 00001c", csr[CSR_IDX_MATH_CTRL]); end
    endtask

    task automatic test_sqrt();
        int dc, cc, p;
        kick(MATH_OP_SQRTU, 24'h0F4240, 24'h0, 24'h0);
        wait_done(0, dc, cc, p);
        checks++; if (csr[CSR_IDX_MATH_RES_LO] !== 24'h0003E8) begin errors++; $display("FAIL sqrt_lo: got %h expected 0003e8", csr[CSR_IDX_MATH_RES_LO]); end
        checks++; if (csr[CSR_IDX_MATH_RES_HI] !== 24'h000000) begin errors++; $display("FAIL sqrt_hi: got %h expected 000000", csr[CSR_IDX_MATH_RES_HI]); end
        checks++; if (cc !== 17) begin errors++; $display("FAIL sqrt_cycle: got %0d expected 17", cc); end
        checks++; if (csr[CSR_IDX_MATH_CTRL] !== 24'h000034) begin errors++; $display("FAIL sqrt_ctrl: got %h expected 000034", csr[CSR_IDX_MATH_CTRL]); end
        // isqrt(16777215) = 4095, remainder 16777215 - 4095^2 = 8190
        kick(MATH_OP_SQRTU, 24'hFFFFFF, 24'h0, 24'h0);
        wait_done(0, dc, cc, p);
        checks++; if (csr[CSR_IDX_MATH_RES_LO] !== 24'h000FFF) begin errors++; $display("FAIL sqrtmax_lo: got %h expected 000fff", csr[CSR_IDX_MATH_RES_LO]); end
        checks++; if (csr[CSR_IDX_MATH_RES_HI] !== 24'h001FFE) begin errors++; $display("FAIL sqrtmax_hi: got %h expected 001ffe", csr[CSR_IDX_MATH_RES_HI]); end
    endtask

    task automatic test_invalid();
        int dc, cc, p, rw;
        logic [23:0] lo_before;
        rw = res_writes;
        lo_before = csr[CSR_IDX_MATH_RES_LO];
        kick(4'd5, 24'h000123, 24'h000456, 24'h0);
        wait_done(0, dc, cc, p);
        checks++; if (cc !== 3) begin errors++; $display("FAIL inv_cycle: got %0d expected 3", cc); end
        checks++; if (csr[CSR_IDX_MATH_CTRL] !== 24'h00005C) begin errors++; $display("FAIL inv_ctrl: got %h expected 00005c", csr[CSR_IDX_MATH_CTRL]); end
        checks++; if (res_writes !== rw) begin errors++; $display("FAIL inv_res_writes: got %0d expected %0d", res_writes, rw); end
        checks++; if (csr[CSR_IDX_MATH_RES_LO] !== lo_before) begin errors++; $display("FAIL inv_lo_kept: got %h expected %h", csr[CSR_IDX_MATH_RES_LO], lo_before); end
    endtask

    task automatic test_busy_writes();
        int dc, cc, p, busy_seen;
        kick(MATH_OP_MULU, 24'h000123, 24'h000456, 24'h0);
        wait_done(5, dc, cc, p);
        checks++; if (csr[CSR_IDX_MATH_RES_LO] !== 24'h04EDC2) begin errors++; $display("FAIL busyw_lo: got %h expected 04edc2", csr[CSR_IDX_MATH_RES_LO]); end
        checks++; if (csr[CSR_IDX_MATH_CTRL] !== 24'h000004) begin errors++; $display("FAIL busyw_ctrl: got %h expected 000004", csr[CSR_IDX_MATH_CTRL]); end
        busy_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge iw_clk); #1;
            if (u_if.ow_busy) busy_seen++;
        end
        checks++; if (busy_seen !== 0) begin errors++; $display("FAIL busyw_restart: busy cycles %0d expected 0", busy_seen); end
    endtask

    task automatic test_reset_mid();
        int dc, cc, p, rw;
        rw = res_writes;
        kick(MATH_OP_MULU, 24'h000123, 24'h000456, 24'h0);
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(posedge iw_clk); #1;
        end
        iw_rst_n = 1'b0;
        #1;
        checks++; if (u_if.ow_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", u_if.ow_busy); end
        checks++; if (u_if.ow_w2_enable !== 1'b0) begin errors++; $display("FAIL rstmid_w2_en: got %b expected 0", u_if.ow_w2_enable); end
        repeat (2) @(posedge iw_clk);
        #1 iw_rst_n = 1'b1;
        repeat (30) @(posedge iw_clk);
        #1;
        checks++; if (res_writes !== rw) begin errors++; $display("FAIL rstmid_res_writes: got %0d expected %0d", res_writes, rw); end
        checks++; if (u_if.ow_busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle: got %b expected 0", u_if.ow_busy); end
        kick(MATH_OP_MULU, 24'd5, 24'd7, 24'h0);
        wait_done(0, dc, cc, p);
        checks++; if (csr[CSR_IDX_MATH_RES_LO] !== 24'h000023) begin errors++; $display("FAIL rstmid_lo: got %h expected 000023", csr[CSR_IDX_MATH_RES_LO]); end
        checks++; if (cc !== 29) begin errors++; $display("FAIL rstmid_cycle: got %0d expected 29", cc); end
    endtask

    initial begin
        test_reset();
        test_mulu();
        test_mul_max();
        test_divu();
        test_sqrt();
        test_invalid();
        test_busy_writes();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
